// File: rtl/sample_frame_packer_pkg.sv
// Shared types and helpers for the sample frame packer.
// A frame is {left, right}, serialised as SYNC, six data bytes, XOR checksum.
package sample_frame_pkg;

    localparam int FRAME_BYTES = 8;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    typedef logic [47:0] frame_t;

    function automatic logic [7:0] frame_byte(
        input frame_t     f,
        input logic [2:0] idx,
        input logic [7:0] sync
    );
        logic [7:0] chk;
        logic [7:0] b;
        chk = f[47:40] ^ f[39:32] ^ f[31:24]
            ^ f[23:16] ^ f[15:8]  ^ f[7:0];
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = f[47:40];
            3'd2:    b = f[39:32];
            3'd3:    b = f[31:24];
            3'd4:    b = f[23:16];
            3'd5:    b = f[15:8];
            3'd6:    b = f[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sample_frame_packer_if.sv
// Byte-wide valid/ready stream from the packer to the UART transmitter.
interface sample_frame_packer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/sample_frame_packer_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a level count.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;

endmodule

// File: rtl/sample_frame_packer.sv
// Queues stereo sample pairs and serialises each as an 8-byte frame.
// Capture is never stalled: a strobe into a full FIFO is dropped and counted.
module sample_frame_packer
    import sample_frame_pkg::*;
#(
    parameter int         SAMPLE_W   = 24,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          sample_stb_i,
    input  logic [SAMPLE_W-1:0]           left_i,
    input  logic [SAMPLE_W-1:0]           right_i,
    sample_frame_packer_if.master         tx,
    input  logic                          ovf_clr_i,
    output logic                          overflow_o,
    output logic [15:0]                   drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    logic [2*SAMPLE_W-1:0] fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_req;
    logic                  drop;
    logic                  pop;
    ser_state_e            state;
    logic [2:0]            idx;
    frame_t                hold;

    assign wr_req = sample_stb_i && enable_i;
    assign drop   = wr_req && fifo_full;
    assign pop    = (state == ST_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (wr_req),
        .wr_data ({left_i, right_i}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        hold  <= frame_t'(fifo_rd);
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                default: begin
                    if (tx.tx_ready) begin
                        idx <= idx + 1'b1;
                        if (idx == 3'(FRAME_BYTES-1)) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign tx.tx_valid = (state == ST_SEND);
    assign tx.tx_data  = tx.tx_valid ? frame_byte(hold, idx, SYNC_BYTE) : 8'h00;

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (ovf_clr_i)
                drop_cnt_o <= 16'd1;
            else if (drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end else if (ovf_clr_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_sample_frame_packer.sv
// Directed bench for sample_frame_packer: framing, backpressure,
// overflow, back-to-back spacing, enable gating and mid-frame reset.
module tb_sample_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sample_stb;
    logic [23:0] left;
    logic [23:0] right;
    logic        ovf_clr;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [3:0]  fifo_level;

    int checks = 0;
    int fails  = 0;

    logic [7:0] exp_single [8] = '{8'hA5, 8'h12, 8'h34, 8'h56,
                                   8'hAB, 8'hCD, 8'hEF, 8'hF9};

    always #5 clk = ~clk;

    sample_frame_packer_if tx_if ();

    sample_frame_packer #(
        .SAMPLE_W   (24),
        .FIFO_DEPTH (8),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .sample_stb_i (sample_stb),
        .left_i       (left),
        .right_i      (right),
        .tx           (tx_if),
        .ovf_clr_i    (ovf_clr),
        .overflow_o   (overflow),
        .drop_cnt_o   (drop_cnt),
        .fifo_level_o (fifo_level)
    );

    function automatic logic [7:0] exp_byte(
        input logic [23:0] l,
        input logic [23:0] r,
        input int          i
    );
        logic [7:0] b [8];
        b[0] = 8'hA5;
        b[1] = l[23:16]; b[2] = l[15:8]; b[3] = l[7:0];
        b[4] = r[23:16]; b[5] = r[15:8]; b[6] = r[7:0];
        b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        return b[i];
    endfunction

    function automatic logic [23:0] fl(input int f);
        return {8'h10 + 8'(f), 8'h20 + 8'(f), 8'h30 + 8'(f)};
    endfunction

    function automatic logic [23:0] fr(input int f);
        return {8'h40 + 8'(f), 8'h50 + 8'(f), 8'h60 + 8'(f)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        left       = l;
        right      = r;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (tx_if.tx_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b want 0", tx_if.tx_valid);
        end
        checks++;
        if (tx_if.tx_data !== 8'h00) begin
            fails++; $display("FAIL reset_data got %h want 00", tx_if.tx_data);
        end
        checks++;
        if (overflow !== 1'b0) begin
            fails++; $display("FAIL reset_ovf got %b want 0", overflow);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_drop got %0d want 0", drop_cnt);
        end
        checks++;
        if (fifo_level !== 4'd0) begin
            fails++; $display("FAIL reset_level got %0d want 0", fifo_level);
        end
    endtask

    task automatic test_single_frame();
        tx_if.tx_ready = 1'b1;
        strobe(24'h123456, 24'hABCDEF);
        checks++;
        if (fifo_level !== 4'd1 || tx_if.tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_n1 level %0d valid %b want 1 0",
                     fifo_level, tx_if.tx_valid);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_single[i]) begin
                fails++;
                $display("FAIL single_byte%0d got v%b %h want v1 %h",
                         i, tx_if.tx_valid, tx_if.tx_data, exp_single[i]);
            end
            tick();
        end
        checks++;
        if (tx_if.tx_valid !== 1'b0 || fifo_level !== 4'd0) begin
            fails++;
            $display("FAIL single_end valid %b level %0d want 0 0",
                     tx_if.tx_valid, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        tx_if.tx_ready = 1'b0;
        strobe(24'h123456, 24'hABCDEF);
        tick();
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            tx_if.tx_ready = (c % 2 == 1);
            checks++;
            if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_single[idx]) begin
                fails++;
                $display("FAIL bp_byte%0d cyc %0d got v%b %h want v1 %h",
                         idx, c, tx_if.tx_valid, tx_if.tx_data, exp_single[idx]);
            end
            if (tx_if.tx_ready) idx++;
            tick();
        end
        checks++;
        if (idx != 8 || tx_if.tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_end bytes %0d valid %b want 8 0",
                     idx, tx_if.tx_valid);
        end
    endtask

    task automatic test_overflow();
        int f;
        int b;
        int seen;
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            strobe(fl(i), fr(i));
            tick();
        end
        checks++;
        if (fifo_level !== 4'd8) begin
            fails++; $display("FAIL ovf_level got %0d want 8", fifo_level);
        end
        checks++;
        if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drop got cnt %0d ovf %b want 1 1", drop_cnt, overflow);
        end
        ovf_clr = 1'b1;
        strobe(fl(10), fr(10));
        ovf_clr = 1'b0;
        checks++;
        if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_clr_vs_drop got cnt %0d ovf %b want 1 1",
                     drop_cnt, overflow);
        end
        tx_if.tx_ready = 1'b1;
        f = 0;
        b = 0;
        for (int c = 0; c < 300 && f < 9; c++) begin
            if (tx_if.tx_valid === 1'b1) begin
                checks++;
                if (tx_if.tx_data !== exp_byte(fl(f), fr(f), b)) begin
                    fails++;
                    $display("FAIL ovf_frame%0d_byte%0d got %h want %h",
                             f, b, tx_if.tx_data, exp_byte(fl(f), fr(f), b));
                end
                b++;
                if (b == 8) begin
                    b = 0;
                    f++;
                end
            end
            tick();
        end
        checks++;
        if (f != 9) begin
            fails++; $display("FAIL ovf_frames got %0d want 9", f);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (tx_if.tx_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || fifo_level !== 4'd0) begin
            fails++;
            $display("FAIL ovf_extra valid cycles %0d level %0d want 0 0",
                     seen, fifo_level);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL ovf_clear got ovf %b cnt %0d want 0 0", overflow, drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        int want_c;
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(fl(20 + i), fr(20 + i));
            tick();
        end
        tx_if.tx_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 24; c++) begin
            if (tx_if.tx_valid === 1'b1) begin
                want_c = cnt + cnt / 8;
                checks++;
                if (c != want_c ||
                    tx_if.tx_data !== exp_byte(fl(20 + cnt / 8), fr(20 + cnt / 8), cnt % 8)) begin
                    fails++;
                    $display("FAIL b2b_byte%0d cyc %0d data %h want cyc %0d data %h",
                             cnt, c, tx_if.tx_data, want_c,
                             exp_byte(fl(20 + cnt / 8), fr(20 + cnt / 8), cnt % 8));
                end
                cnt++;
            end
            tick();
        end
        checks++;
        if (cnt != 24) begin
            fails++; $display("FAIL b2b_count got %0d want 24", cnt);
        end
    endtask

    task automatic test_enable_reset();
        int seen;
        enable = 1'b0;
        tx_if.tx_ready = 1'b1;
        strobe(24'h0F0F0F, 24'hF0F0F0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (tx_if.tx_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || drop_cnt !== 16'd0 || fifo_level !== 4'd0) begin
            fails++;
            $display("FAIL en_low valid cycles %0d drop %0d level %0d want 0 0 0",
                     seen, drop_cnt, fifo_level);
        end
        enable = 1'b1;
        tx_if.tx_ready = 1'b0;
        strobe(fl(30), fr(30));
        tick();
        strobe(fl(31), fr(31));
        tick();
        tx_if.tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_byte(fl(30), fr(30), 4)) begin
            fails++;
            $display("FAIL rst_pre got v%b %h want v1 %h",
                     tx_if.tx_valid, tx_if.tx_data, exp_byte(fl(30), fr(30), 4));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (tx_if.tx_valid !== 1'b0 || fifo_level !== 4'd0 || tx_if.tx_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid got v%b level %0d data %h want 0 0 00",
                     tx_if.tx_valid, fifo_level, tx_if.tx_data);
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (tx_if.tx_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            fails++; $display("FAIL rst_no_resume valid cycles %0d want 0", seen);
        end
        strobe(fl(40), fr(40));
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_byte(fl(40), fr(40), i)) begin
                fails++;
                $display("FAIL rst_fresh_byte%0d got v%b %h want v1 %h",
                         i, tx_if.tx_valid, tx_if.tx_data, exp_byte(fl(40), fr(40), i));
            end
            tick();
        end
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        sample_stb     = 1'b0;
        left           = '0;
        right          = '0;
        ovf_clr        = 1'b0;
        tx_if.tx_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_enable_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
